// File: rtl/game_pkg.sv
// Shared types and elaboration-time helpers for the game timer.
package game_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  typedef enum logic {
    MODE_SAT  = 1'b0,
    MODE_WRAP = 1'b1
  } mode_e;

  // A one-cycle prescaler still needs a 1-bit register to stay legal.
  function automatic int unsigned prescale_width(input int unsigned prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

  function automatic logic [63:0] terminal_val(input int unsigned width, input dir_e dir);
    return (dir == DIR_UP) ? ((64'd1 << width) - 64'd1) : 64'd0;
  endfunction

endpackage

// File: rtl/game_prescaler.sv
// Divides qualified enable cycles into step ticks, one every PRESCALE enables.
module game_prescaler
  import game_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic sync_clr_i,
  output logic step_o
);

  localparam int unsigned   PW   = prescale_width(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;

  // With PRESCALE=1 LAST is zero, so cnt_q never leaves 0 and step_o follows en_i.
  assign step_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (sync_clr_i) begin
      cnt_d = '0;
    end else if (step_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/game_timer.sv
// Parametrised up/down game timer with prescaler, wrap/saturate end mode,
// terminal-count and wrap pulses, and a sticky done flag.
module game_timer
  import game_pkg::*;
#(
  parameter int unsigned      WIDTH     = 5,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}},
  parameter int unsigned      PRESCALE  = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dir_i,
  input  logic             mode_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o,
  output logic             wrap_o,
  output logic             done_o
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(terminal_val(WIDTH, DIR_UP));

  dir_e  dir;
  mode_e mode;
  logic  step;

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] opposite;
  logic [WIDTH-1:0] next;

  assign dir  = dir_e'(dir_i);
  assign mode = mode_e'(mode_i);

  game_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en_i      (en_i),
    .sync_clr_i(clear_i || load_i),
    .step_o    (step)
  );

  // Clear and load take the whole cycle, so the prescaler's step is ignored then.
  always_comb begin
    term     = (dir == DIR_UP) ? MAX_VAL : '0;
    opposite = (dir == DIR_UP) ? '0 : MAX_VAL;
    next     = (dir == DIR_UP) ? count_q + 1'b1 : count_q - 1'b1;
    count_d  = count_q;
    tc_d     = 1'b0;
    wrap_d   = 1'b0;
    done_d   = done_q;
    if (clear_i) begin
      count_d = RESET_VAL;
      done_d  = 1'b0;
    end else if (load_i) begin
      count_d = load_val_i;
      done_d  = 1'b0;
    end else if (step) begin
      if (count_q != term) begin
        count_d = next;
        if (next == term) begin
          tc_d   = 1'b1;
          done_d = done_q || (mode == MODE_SAT);
        end
      end else if (mode == MODE_WRAP) begin
        count_d = opposite;
        wrap_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= RESET_VAL;
      tc_q    <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = tc_q;
  assign wrap_o  = wrap_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_game_timer.sv
// Scoreboard bench for game_timer: three configurations share one stimulus set,
// each scenario task checks the instance it targets.
module tb_game_timer;

  logic       clk;
  logic       rst;
  logic       en;
  logic       clr;
  logic       ld;
  logic       dir;
  logic       mode;
  logic [4:0] val5;
  logic [7:0] val8;

  logic [4:0] a_count, b_count;
  logic [7:0] c_count;
  logic       a_tc, a_wrap, a_done;
  logic       b_tc, b_wrap, b_done;
  logic       c_tc, c_wrap, c_done;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected observations packed as {count[7:0], tc, wrap, done}.
  logic [10:0] sb[$];

  game_timer u_a (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clear_i(clr), .load_i(ld),
    .load_val_i(val5), .dir_i(dir), .mode_i(mode),
    .count_o(a_count), .tc_o(a_tc), .wrap_o(a_wrap), .done_o(a_done)
  );

  game_timer #(.PRESCALE(4)) u_b (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clear_i(clr), .load_i(ld),
    .load_val_i(val5), .dir_i(dir), .mode_i(mode),
    .count_o(b_count), .tc_o(b_tc), .wrap_o(b_wrap), .done_o(b_done)
  );

  game_timer #(.WIDTH(8), .RESET_VAL(8'd100)) u_c (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clear_i(clr), .load_i(ld),
    .load_val_i(val8), .dir_i(dir), .mode_i(mode),
    .count_o(c_count), .tc_o(c_tc), .wrap_o(c_wrap), .done_o(c_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [10:0] obs(input int sel);
    case (sel)
      0:       return {3'b000, a_count, a_tc, a_wrap, a_done};
      1:       return {3'b000, b_count, b_tc, b_wrap, b_done};
      default: return {c_count, c_tc, c_wrap, c_done};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ctl is {clear, load, en, dir, mode}.
  task automatic drive(input logic [4:0] ctl, input logic [7:0] v, input logic [10:0] e);
    {clr, ld, en, dir, mode} = ctl;
    val5 = v[4:0];
    val8 = v;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    {clr, ld, en, dir, mode} = 5'b00000;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [10:0] got, e;
    {clr, ld, en, dir, mode} = 5'b00000;
    val5 = 5'd0;
    val8 = 8'd0;
    rst  = 1'b1;
    sb.push_back({8'd31, 3'b000});
    sb.push_back({8'd31, 3'b000});
    sb.push_back({8'd100, 3'b000});
    #1;
    for (int s = 0; s < 3; s++) begin
      got = obs(s);
      e   = sb.pop_front();
      n_checks++;
      if (got !== e)
        $display("[TB] FAIL reset[dut%0d]: got count=%0d tc/wrap/done=%b, expected count=%0d tc/wrap/done=%b",
                 s, got[10:3], got[2:0], e[10:3], e[2:0]);
      else n_pass++;
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_sat_down();
    logic [10:0] got, e;
    logic [7:0]  c;
    do_reset();
    for (int i = 1; i <= 40; i++) begin
      c = (i >= 31) ? 8'd0 : 8'(31 - i);
      drive(5'b00100, 8'd0, {c, (i == 31), 1'b0, (i >= 31)});
      tick();
      got = obs(0);
      e   = sb.pop_front();
      n_checks++;
      if (got !== e)
        $display("[TB] FAIL sat_down[%0d]: got count=%0d tc/wrap/done=%b, expected count=%0d tc/wrap/done=%b",
                 i, got[10:3], got[2:0], e[10:3], e[2:0]);
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    logic [4:0]  ctl   [9] = '{5'b01011, 5'b00111, 5'b00111, 5'b00111, 5'b01011,
                               5'b01001, 5'b00101, 5'b00101, 5'b00101};
    logic [7:0]  v     [9] = '{8'd30, 8'd0, 8'd0, 8'd0, 8'd31, 8'd1, 8'd0, 8'd0, 8'd0};
    logic [10:0] exp_v [9] = '{{8'd30, 3'b000}, {8'd31, 3'b100}, {8'd0, 3'b010},
                               {8'd1, 3'b000},  {8'd31, 3'b000}, {8'd1, 3'b000},
                               {8'd0, 3'b100},  {8'd31, 3'b010}, {8'd30, 3'b000}};
    logic [10:0] got, e;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(ctl[i], v[i], exp_v[i]);
      tick();
      got = obs(0);
      e   = sb.pop_front();
      n_checks++;
      if (got !== e)
        $display("[TB] FAIL wrap[%0d]: got count=%0d tc/wrap/done=%b, expected count=%0d tc/wrap/done=%b",
                 i, got[10:3], got[2:0], e[10:3], e[2:0]);
      else n_pass++;
    end
  endtask

  task automatic test_prescale();
    logic        en_seq [12] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
                                 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [7:0]  cnt    [12] = '{8'd31, 8'd31, 8'd31, 8'd31, 8'd30, 8'd30,
                                 8'd30, 8'd30, 8'd30, 8'd30, 8'd30, 8'd29};
    logic [10:0] got, e;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive({2'b00, en_seq[i], 2'b00}, 8'd0, {cnt[i], 3'b000});
      tick();
      got = obs(1);
      e   = sb.pop_front();
      n_checks++;
      if (got !== e)
        $display("[TB] FAIL prescale[%0d]: got count=%0d tc/wrap/done=%b, expected count=%0d tc/wrap/done=%b",
                 i, got[10:3], got[2:0], e[10:3], e[2:0]);
      else n_pass++;
    end
  endtask

  task automatic test_clear_load();
    logic [4:0]  ctl   [9] = '{5'b01000, 5'b11100, 5'b01100, 5'b01000, 5'b00100,
                               5'b00100, 5'b01100, 5'b01001, 5'b10101};
    logic [7:0]  v     [9] = '{8'd1, 8'd5, 8'd5, 8'd1, 8'd0, 8'd0, 8'd5, 8'd0, 8'd0};
    logic [10:0] exp_v [9] = '{{8'd1, 3'b000}, {8'd31, 3'b000}, {8'd5, 3'b000},
                               {8'd1, 3'b000}, {8'd0, 3'b101},  {8'd0, 3'b001},
                               {8'd5, 3'b000}, {8'd0, 3'b000},  {8'd31, 3'b000}};
    logic [10:0] got, e;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(ctl[i], v[i], exp_v[i]);
      tick();
      got = obs(0);
      e   = sb.pop_front();
      n_checks++;
      if (got !== e)
        $display("[TB] FAIL clear_load[%0d]: got count=%0d tc/wrap/done=%b, expected count=%0d tc/wrap/done=%b",
                 i, got[10:3], got[2:0], e[10:3], e[2:0]);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    logic [4:0]  ctl   [7] = '{5'b01000, 5'b00100, 5'b00100, 5'b00100,
                               5'b00100, 5'b00100, 5'b00100};
    logic [7:0]  v     [7] = '{8'd12, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    logic [10:0] exp_v [7] = '{{8'd12, 3'b000}, {8'd12, 3'b000}, {8'd12, 3'b000},
                               {8'd31, 3'b000}, {8'd31, 3'b000}, {8'd31, 3'b000},
                               {8'd30, 3'b000}};
    logic [10:0] got, e;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      if (i == 3) begin
        // Prescaler sits at 2 with count 12: pull reset between clock edges.
        #2;
        rst = 1'b1;
        sb.push_back({8'd31, 3'b000});
        #1;
        got = obs(1);
        e   = sb.pop_front();
        n_checks++;
        if (got !== e)
          $display("[TB] FAIL async_reset[mid]: got count=%0d tc/wrap/done=%b, expected count=%0d tc/wrap/done=%b",
                   got[10:3], got[2:0], e[10:3], e[2:0]);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
      end
      drive(ctl[i], v[i], exp_v[i]);
      tick();
      got = obs(1);
      e   = sb.pop_front();
      n_checks++;
      if (got !== e)
        $display("[TB] FAIL async_reset[%0d]: got count=%0d tc/wrap/done=%b, expected count=%0d tc/wrap/done=%b",
                 i, got[10:3], got[2:0], e[10:3], e[2:0]);
      else n_pass++;
    end
  endtask

  task automatic test_dir_flip();
    logic [4:0]  ctl   [4] = '{5'b00100, 5'b00100, 5'b00110, 5'b00110};
    logic [10:0] exp_v [4] = '{{8'd99, 3'b000}, {8'd98, 3'b000},
                               {8'd99, 3'b000}, {8'd100, 3'b000}};
    logic [10:0] got, e;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(ctl[i], 8'd0, exp_v[i]);
      tick();
      got = obs(2);
      e   = sb.pop_front();
      n_checks++;
      if (got !== e)
        $display("[TB] FAIL dir_flip[%0d]: got count=%0d tc/wrap/done=%b, expected count=%0d tc/wrap/done=%b",
                 i, got[10:3], got[2:0], e[10:3], e[2:0]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_sat_down();
    test_wrap();
    test_prescale();
    test_clear_load();
    test_async_reset();
    test_dir_flip();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
